// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Owns the HI/LO registers and raises busy while mult/div is in flight.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;

    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;

    // Result datapath from the operands latched at the start edge.
    // A signed product's low 64 bits equal the unsigned product of
    // the sign-extended operands, so one multiplier serves both.
    always_comb begin
        ea   = {32'd0, ra};
        eb   = {32'd0, rb};
        quo  = 32'd0;
        rem  = 32'd0;
        dz   = (rb == 32'd0);
        if (rop == OP_MULT) begin
            ea = {{32{ra[31]}}, ra};
            eb = {{32{rb[31]}}, rb};
        end
        prod = ea * eb;
        if (dz) begin
            quo = 32'd0;
            rem = 32'd0;
        end else if (rop == OP_DIVU) begin
            quo = ra / rb;
            rem = ra % rb;
        end else if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = $signed(ra) / $signed(rb);
            rem = $signed(ra) % $signed(rb);
        end
    end

    // Control FSM, cycle counter, operand latch and HI/LO writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 32'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            ra    <= 32'd0;
            rb    <= 32'd0;
            rop   <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state <= MUL;
                                cnt   <= MULT_CYCLES;
                                busy  <= 1'b1;
                                ra    <= a;
                                rb    <= b;
                                rop   <= op;
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= DIV;
                                cnt   <= DIV_CYCLES;
                                busy  <= 1'b1;
                                ra    <= a;
                                rb    <= b;
                                rop   <= op;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                    end
                end
                DIV: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!dz) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge after E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        a     = 32'hDEAD_BEEF;
        b     = 32'hDEAD_BEEF;
    endtask

    // Count falling edges with busy high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(cyc);
        chk("mult_cyc", cyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("multu_cyc", cyc, 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        chk("div_cyc", cyc, 32'd10);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        chk("divu_cyc", cyc, 32'd10);
        chk("divu_hi", hi, 32'h0000_0001);
        chk("divu_lo", lo, 32'h7FFF_FFFC);

        issue(3'd5, 32'h11, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        issue(3'd6, 32'h22, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_hi_kept", hi, 32'h11);

        issue(3'd7, 32'h99, 32'h99);
        chk("op7_hi", hi, 32'h11);
        chk("op7_lo", lo, 32'h22);
        chk("op7_busy", {31'd0, busy}, 32'd0);

        issue(3'd3, 32'h1234, 32'd0);
        wait_done(cyc);
        chk("dz_cyc", cyc, 32'd10);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("ovf_cyc", cyc, 32'd10);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h8000_0000);

        issue(3'd4, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h55;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        chk("ign_lo_mid", lo, 32'h8000_0000);
        chk("ign_busy_mid", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        chk("ign_cyc", cyc, 32'd8);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);

        issue(3'd1, 32'd3, 32'd5);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_hi", hi, 32'd0);
        chk("amid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_hi", hi, 32'd0);
        chk("post_lo", lo, 32'd0);

        issue(3'd1, 32'd3, 32'd5);
        wait_done(cyc);
        chk("re_cyc", cyc, 32'd5);
        chk("re_hi", hi, 32'd0);
        chk("re_lo", lo, 32'd15);

        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc);
        chk("b2b_cyc", cyc, 32'd5);
        chk("b2b_hi", hi, 32'h4000_0000);
        chk("b2b_lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
